// File: rtl/ptcalc_mul_pipe_sxu.sv
// Pipelined signed x unsigned multiplier with round-half-up rescale, optional saturation,
// a valid/ready handshake with global stall, sideband tag pass-through and a saturation counter.
module ptcalc_mul_pipe_sxu #(
    parameter int A_WIDTH   = 24,
    parameter int B_WIDTH   = 15,
    parameter int OUT_WIDTH = 24,
    parameter int SHIFT     = 12,
    parameter int NUM_STAGE = 3,
    parameter int ROUND_EN  = 1,
    parameter int SAT_EN    = 1,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_p,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_sat,
    input  logic                 cnt_clr,
    output logic [15:0]          sat_cnt
);

    localparam int PW  = A_WIDTH + B_WIDTH;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [PW:0] RND =
        (ROUND_EN != 0 && SHIFT > 0) ? ((PW + 1)'(1) << RSH) : '0;
    // Output range limits, sign-extended to the width of the shifted product
    localparam logic signed [PW:0] SMAX = {{(PW + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [PW:0] SMIN = {{(PW + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [PW-1:0]  a_ext;
    logic signed [PW-1:0]  b_ext;
    logic signed [PW-1:0]  full;
    logic signed [PW:0]    rnd_sum;
    logic signed [PW:0]    shifted;
    logic [OUT_WIDTH-1:0]  res_p;
    logic                  res_sat;
    logic                  en;

    logic [NUM_STAGE-1:0]  vld;
    logic [NUM_STAGE-1:0]  sat;
    logic [OUT_WIDTH-1:0]  dat [NUM_STAGE];
    logic [TAG_WIDTH-1:0]  tg  [NUM_STAGE];

    // Both operands extended to the full product width, so the product is exact
    assign a_ext   = {{B_WIDTH{in_a[A_WIDTH-1]}}, in_a};
    assign b_ext   = {{A_WIDTH{1'b0}}, in_b};
    assign full    = a_ext * b_ext;
    assign rnd_sum = {full[PW-1], full} + RND;
    assign shifted = rnd_sum >>> SHIFT;

    always_comb begin
        res_p   = shifted[OUT_WIDTH-1:0];
        res_sat = 1'b0;
        if (SAT_EN != 0) begin
            if (shifted > SMAX) begin
                res_p   = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
                res_sat = 1'b1;
            end else if (shifted < SMIN) begin
                res_p   = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
                res_sat = 1'b1;
            end
        end
    end

    assign en        = !vld[NUM_STAGE-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld[NUM_STAGE-1];
    assign out_p     = dat[NUM_STAGE-1];
    assign out_tag   = tg[NUM_STAGE-1];
    assign out_sat   = sat[NUM_STAGE-1];

    // Whole pipe advances or holds together; bubbles are never collapsed
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld <= '0;
            sat <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                dat[i] <= '0;
                tg[i]  <= '0;
            end
        end else if (en) begin
            vld[0] <= in_valid && in_ready;
            sat[0] <= res_sat;
            dat[0] <= res_p;
            tg[0]  <= in_tag;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld[i] <= vld[i-1];
                sat[i] <= sat[i-1];
                dat[i] <= dat[i-1];
                tg[i]  <= tg[i-1];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_cnt <= '0;
        end else if (cnt_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && out_sat && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ptcalc_mul_pipe_sxu.sv
// Directed bench for ptcalc_mul_pipe_sxu: default build plus a floor/wrap build sharing the same inputs,
// checked with immediate assertions against hand-computed values.
module tb_ptcalc_mul_pipe_sxu;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic [23:0] in_a;
    logic [14:0] in_b;
    logic [7:0]  in_tag;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready,  nr_in_ready;
    logic        out_valid, nr_out_valid;
    logic [23:0] out_p,     nr_out_p;
    logic [7:0]  out_tag,   nr_out_tag;
    logic        out_sat,   nr_out_sat;
    logic [15:0] sat_cnt,   nr_sat_cnt;

    int checkCnt = 0;
    int passCnt  = 0;
    int failCnt  = 0;
    int sent, rcv;
    logic [7:0]  lastTag;
    logic [23:0] lastP;
    logic        lastStall;
    logic        sawValid;

    always #5 ap_clk = ~ap_clk;

    ptcalc_mul_pipe_sxu dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag), .out_sat(out_sat),
        .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
    );

    ptcalc_mul_pipe_sxu #(.ROUND_EN(0), .SAT_EN(0)) dut_nr (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(nr_in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(nr_out_valid), .out_ready(out_ready),
        .out_p(nr_out_p), .out_tag(nr_out_tag), .out_sat(nr_out_sat),
        .cnt_clr(cnt_clr), .sat_cnt(nr_sat_cnt)
    );

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt = passCnt + 1;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drives one beat for one edge, then waits until it sits on the output (latency 3)
    task automatic applyStimulus(input logic [23:0] a, input logic [14:0] b, input logic [7:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        #12;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_p", out_p, 0);
        checkOutput("rst_tag", out_tag, 0);
        checkOutput("rst_sat", out_sat, 0);
        checkOutput("rst_cnt", sat_cnt, 0);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b1;
        tick();

        // Basic multiply and latency
        in_valid = 1'b1; in_a = 24'h001000; in_b = 15'h0003; in_tag = 8'h01;
        #1;
        checkOutput("t1_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        checkOutput("t1_lat_k", out_valid, 0);
        tick();
        checkOutput("t1_lat_k1", out_valid, 0);
        tick();
        checkOutput("t1_lat_k2", out_valid, 1);
        checkOutput("t1_p", out_p, 3);
        checkOutput("t1_tag", out_tag, 8'h01);
        checkOutput("t1_sat", out_sat, 0);
        checkOutput("t1_nr_p", nr_out_p, 3);
        tick();
        checkOutput("t1_drain", out_valid, 0);

        // Rounding at exactly one half
        applyStimulus(24'h000001, 15'h0800, 8'h02);
        checkOutput("t2_half_p", out_p, 1);
        checkOutput("t2_half_floor", nr_out_p, 0);
        tick();
        applyStimulus(24'hFFFFFF, 15'h0800, 8'h03);
        checkOutput("t2_neghalf_p", out_p, 0);
        checkOutput("t2_neghalf_floor", nr_out_p, 24'hFFFFFF);
        tick();

        // Saturation at both ends, and wrap in the non-saturating build
        applyStimulus(24'h7FFFFF, 15'h7FFF, 8'h04);
        checkOutput("t3_max_p", out_p, 24'h7FFFFF);
        checkOutput("t3_max_sat", out_sat, 1);
        checkOutput("t3_max_wrap", nr_out_p, 24'hFFF7F8);
        checkOutput("t3_max_nrsat", nr_out_sat, 0);
        checkOutput("t3_cnt0", sat_cnt, 0);
        tick();
        checkOutput("t3_cnt1", sat_cnt, 1);
        applyStimulus(24'h800000, 15'h7FFF, 8'h05);
        checkOutput("t3_min_p", out_p, 24'h800000);
        checkOutput("t3_min_sat", out_sat, 1);
        checkOutput("t3_min_wrap", nr_out_p, 24'h000800);
        tick();
        checkOutput("t3_cnt2", sat_cnt, 2);
        checkOutput("t3_nr_cnt", nr_sat_cnt, 0);

        // Stream of tags 0..7 with a 3-cycle downstream stall
        sent = 0;
        rcv = 0;
        lastStall = 1'b0;
        lastTag = '0;
        lastP = '0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_a      = 24'(sent) << 12;
            in_b      = 15'h0001;
            in_tag    = 8'(sent);
            out_ready = !(cyc >= 4 && cyc < 7);
            #1;
            if (out_valid && !out_ready) begin
                checkOutput("t4_stall_ready", in_ready, 0);
                if (lastStall) begin
                    checkOutput("t4_hold_tag", out_tag, lastTag);
                    checkOutput("t4_hold_p", out_p, lastP);
                end
                lastStall = 1'b1;
            end else begin
                lastStall = 1'b0;
            end
            lastTag = out_tag;
            lastP = out_p;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checkOutput("t4_tag", out_tag, 64'(rcv));
                checkOutput("t4_p", out_p, 64'(rcv));
                rcv++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("t4_count", rcv, 8);
        tick();
        tick();
        checkOutput("t4_no_dup", out_valid, 0);

        // Asynchronous reset with three beats held in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 24'h7FFFFF; in_b = 15'h7FFF; in_tag = 8'(8'h10 + i);
            tick();
        end
        in_valid = 1'b0;
        checkOutput("t5_inflight", out_valid, 1);
        ap_rst_n = 1'b0;
        #2;
        checkOutput("t5_async_valid", out_valid, 0);
        checkOutput("t5_async_cnt", sat_cnt, 0);
        checkOutput("t5_async_tag", out_tag, 0);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b1;
        out_ready = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("t5_no_ghost", sawValid, 0);
        applyStimulus(24'h001000, 15'h0002, 8'hA5);
        checkOutput("t5_new_valid", out_valid, 1);
        checkOutput("t5_new_tag", out_tag, 8'hA5);
        checkOutput("t5_new_p", out_p, 2);
        tick();

        // Counter saturation at 16'hFFFF, then clear beating a same-cycle increment
        in_valid = 1'b1; in_a = 24'h7FFFFF; in_b = 15'h7FFF; in_tag = 8'h66;
        repeat (100) tick();
        checkOutput("t6_cnt_mid", sat_cnt, 97);
        repeat (65440) tick();
        checkOutput("t6_cnt_stick", sat_cnt, 16'hFFFF);
        tick();
        checkOutput("t6_cnt_stick2", sat_cnt, 16'hFFFF);
        cnt_clr = 1'b1;
        checkOutput("t6_clr_hs", out_valid && out_sat, 1);
        tick();
        cnt_clr = 1'b0;
        checkOutput("t6_clr", sat_cnt, 0);
        tick();
        checkOutput("t6_after_clr", sat_cnt, 1);
        in_valid = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
